// File: rtl/jcpu_pkg.sv
// jcpu_pkg: shared opcodes, flag indices, step indices and monitor states
package jcpu_pkg;
  localparam logic [2:0] OP_LD    = 3'd0;
  localparam logic [2:0] OP_ST    = 3'd1;
  localparam logic [2:0] OP_DATA  = 3'd2;
  localparam logic [2:0] OP_JMPR  = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JMPIF = 3'd5;
  localparam logic [2:0] OP_CLF   = 3'd6;
  localparam logic [2:0] OP_IO    = 3'd7;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SHR  = 3'd1;
  localparam logic [2:0] ALU_SHL  = 3'd2;
  localparam logic [2:0] ALU_NOT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;
  localparam logic [2:0] ALU_CMP  = 3'd7;
  localparam int F_C = 3;
  localparam int F_A = 2;
  localparam int F_E = 1;
  localparam int F_Z = 0;
  localparam int S1 = 0;
  localparam int S2 = 1;
  localparam int S3 = 2;
  localparam int S4 = 3;
  localparam int S5 = 4;
  localparam int S6 = 5;
  typedef enum logic [1:0] {MON_WAIT, MON_TRACK, MON_ERR} mon_e;
endpackage

// File: rtl/jflags.sv
// jflags: 4-bit flags register with synchronous reset and load enable
module jflags (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  logic [3:0] flags_q;
  // capture new flags when loaded, clear on reset
  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else if (load_i) flags_q <= d_i;
  end
  assign q_o = flags_q;
endmodule

// File: rtl/jcontrol.sv
// jcontrol: instruction-cycle strobe decode, flags register and stepper sequence monitor
module jcontrol
  import jcpu_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clke,
  input  logic            clks,
  input  logic [0:5]      step,
  input  logic [7:0]      ir,
  input  logic [3:0]      alu_flags,
  output logic            bus1,
  output logic [2:0]      alu_op,
  output logic            carry_in,
  output logic [NREG-1:0] ena_reg,
  output logic [NREG-1:0] set_reg,
  output logic            ena_ram,
  output logic            set_ram,
  output logic            set_mar,
  output logic            ena_iar,
  output logic            set_iar,
  output logic            set_ir,
  output logic            ena_acc,
  output logic            set_acc,
  output logic            set_tmp,
  output logic [3:0]      flags,
  output logic            seq_err
);
  logic            oh;
  logic [0:5]      s;
  logic [2:0]      op;
  logic [NREG-1:0] reg_a, reg_b, e_reg, s_reg;
  logic            e_ram, e_iar, e_acc, s_ram, s_mar, s_iar, s_ir, s_acc, s_tmp, s_flags, clf;
  mon_e            state_q, state_d;
  logic [0:5]      prev_q, prev_d;

  assign oh    = $onehot(step);
  assign s     = oh ? step : 6'b000000;
  assign op    = ir[6:4];
  assign reg_a = NREG'(1) << ir[3:2];
  assign reg_b = NREG'(1) << ir[1:0];

  // ungated decode of the current step and instruction; a non-one-hot step decodes to nothing
  always_comb begin
    bus1 = 1'b0; alu_op = ALU_ADD; carry_in = 1'b0;
    e_reg = '0; s_reg = '0;
    e_ram = 1'b0; e_iar = 1'b0; e_acc = 1'b0;
    s_ram = 1'b0; s_mar = 1'b0; s_iar = 1'b0; s_ir = 1'b0; s_acc = 1'b0; s_tmp = 1'b0;
    s_flags = 1'b0; clf = 1'b0;
    if (s[S1]) begin bus1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
    if (s[S2]) begin e_ram = 1'b1; s_ir = 1'b1; end
    if (s[S3]) begin e_acc = 1'b1; s_iar = 1'b1; end
    if (ir[7]) begin
      if (s[S4]) begin e_reg = reg_b; s_tmp = 1'b1; end
      if (s[S5]) begin e_reg = reg_a; alu_op = op; carry_in = flags[F_C]; s_acc = 1'b1; s_flags = 1'b1; end
      if (s[S6] && op != ALU_CMP) begin e_acc = 1'b1; s_reg = reg_b; end
    end else begin
      case (op)
        OP_LD: begin
          if (s[S4]) begin e_reg = reg_a; s_mar = 1'b1; end
          if (s[S5]) begin e_ram = 1'b1; s_reg = reg_b; end
        end
        OP_ST: begin
          if (s[S4]) begin e_reg = reg_a; s_mar = 1'b1; end
          if (s[S5]) begin e_reg = reg_b; s_ram = 1'b1; end
        end
        OP_DATA: begin
          if (s[S4]) begin bus1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
          if (s[S5]) begin e_ram = 1'b1; s_reg = reg_b; end
          if (s[S6]) begin e_acc = 1'b1; s_iar = 1'b1; end
        end
        OP_JMPR: if (s[S4]) begin e_reg = reg_b; s_iar = 1'b1; end
        OP_JMP: begin
          if (s[S4]) begin e_iar = 1'b1; s_mar = 1'b1; end
          if (s[S5]) begin e_ram = 1'b1; s_iar = 1'b1; end
        end
        OP_JMPIF: begin
          if (s[S4]) begin bus1 = 1'b1; e_iar = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
          if (s[S5]) begin e_acc = 1'b1; s_iar = 1'b1; end
          if (s[S6] && (ir[3:0] & flags) != 4'b0000) begin e_ram = 1'b1; s_iar = 1'b1; end
        end
        OP_CLF: if (s[S4]) begin bus1 = 1'b1; s_flags = 1'b1; clf = 1'b1; end
        default: ;
      endcase
    end
  end

  assign ena_reg = (clke & ~reset) ? e_reg : '0;
  assign set_reg = (clks & ~reset) ? s_reg : '0;
  assign ena_ram = clke & ~reset & e_ram;
  assign ena_iar = clke & ~reset & e_iar;
  assign ena_acc = clke & ~reset & e_acc;
  assign set_ram = clks & ~reset & s_ram;
  assign set_mar = clks & ~reset & s_mar;
  assign set_iar = clks & ~reset & s_iar;
  assign set_ir  = clks & ~reset & s_ir;
  assign set_acc = clks & ~reset & s_acc;
  assign set_tmp = clks & ~reset & s_tmp;

  jflags u_flags (
    .clk    (clk),
    .reset  (reset),
    .load_i (clks & s_flags),
    .d_i    (clf ? 4'b0000 : alu_flags),
    .q_o    (flags)
  );

  // monitor next state: wait for step 1, then allow only hold or advance by one; errors are sticky
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    case (state_q)
      MON_WAIT: if (step == 6'b100000) begin state_d = MON_TRACK; prev_d = step; end
      MON_TRACK:
        if (step == {prev_q[5], prev_q[0:4]}) prev_d = step;
        else if (step != prev_q) state_d = MON_ERR;
      default: state_d = MON_ERR;
    endcase
    if (!oh) state_d = MON_ERR;
  end

  // monitor state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MON_WAIT;
      prev_q  <= 6'b000000;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  assign seq_err = state_q == MON_ERR;
endmodule

// File: tb/tb_jcontrol.sv
// tb_jcontrol: directed checks of strobe decode, flags register and sequence monitor
module tb_jcontrol;
  logic       clk = 1'b0;
  logic       reset, clke, clks;
  logic [0:5] step;
  logic [7:0] ir;
  logic [3:0] alu_flags;
  logic       bus1, carry_in;
  logic [2:0] alu_op;
  logic [3:0] ena_reg, set_reg, flags;
  logic       ena_ram, set_ram, set_mar, ena_iar, set_iar, set_ir, ena_acc, set_acc, set_tmp, seq_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  jcontrol #(.NREG(4)) dut (
    .clk(clk), .reset(reset), .clke(clke), .clks(clks), .step(step), .ir(ir),
    .alu_flags(alu_flags), .bus1(bus1), .alu_op(alu_op), .carry_in(carry_in),
    .ena_reg(ena_reg), .set_reg(set_reg), .ena_ram(ena_ram), .set_ram(set_ram),
    .set_mar(set_mar), .ena_iar(ena_iar), .set_iar(set_iar), .set_ir(set_ir),
    .ena_acc(ena_acc), .set_acc(set_acc), .set_tmp(set_tmp), .flags(flags), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go(input int k);
    @(negedge clk);
    step = 6'b100000 >> k;
    #1;
  endtask

  task automatic run(input logic [7:0] i, input logic [3:0] af);
    ir = i;
    alu_flags = af;
    for (int k = 0; k < 6; k++) go(k);
  endtask

  initial begin
    reset = 1'b1; clke = 1'b1; clks = 1'b1; step = 6'b100000; ir = 8'h00; alu_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena_iar", ena_iar, 0);
    chk("rst_set_mar", set_mar, 0);
    chk("rst_flags", flags, 0);
    chk("rst_seq_err", seq_err, 0);
    @(negedge clk);
    reset = 1'b0;
    ir = 8'h86;
    go(0);
    chk("s1_bus1", bus1, 1);
    chk("s1_ena_iar", ena_iar, 1);
    chk("s1_set_mar", set_mar, 1);
    chk("s1_set_acc", set_acc, 1);
    chk("s1_alu_op", alu_op, 0);
    chk("s1_carry", carry_in, 0);
    chk("s1_seq_err", seq_err, 0);
    go(1);
    chk("s2_ena_ram", ena_ram, 1);
    chk("s2_set_ir", set_ir, 1);
    go(2);
    chk("s3_ena_acc", ena_acc, 1);
    chk("s3_set_iar", set_iar, 1);
    go(3); go(4); go(5);
    chk("pre_flags_add", flags, 4'b0000);
    run(8'h80, 4'b1000);
    chk("prime_c", flags, 4'b1000);
    chk("add00_set_reg", set_reg, 4'b0001);
    ir = 8'h86; alu_flags = 4'b1001;
    go(0); go(1); go(2); go(3);
    chk("add_s4_ena_reg", ena_reg, 4'b0100);
    chk("add_s4_set_tmp", set_tmp, 1);
    go(4);
    chk("add_s5_ena_reg", ena_reg, 4'b0010);
    chk("add_s5_alu_op", alu_op, 0);
    chk("add_s5_carry", carry_in, 1);
    chk("add_s5_set_acc", set_acc, 1);
    go(5);
    chk("add_flags", flags, 4'b1001);
    chk("add_s6_set_reg", set_reg, 4'b0100);
    chk("add_s6_ena_acc", ena_acc, 1);
    ir = 8'hF6; alu_flags = 4'b0010;
    go(0); go(1); go(2); go(3); go(4);
    chk("cmp_s5_alu_op", alu_op, 7);
    chk("cmp_s5_ena_reg", ena_reg, 4'b0010);
    go(5);
    chk("cmp_s6_set_reg", set_reg, 0);
    chk("cmp_s6_ena_acc", ena_acc, 0);
    chk("cmp_flags", flags, 4'b0010);
    run(8'h80, 4'b0000);
    chk("clr_flags", flags, 4'b0000);
    ir = 8'h58;
    go(0); go(1); go(2); go(3);
    chk("jif_s4_bus1", bus1, 1);
    chk("jif_s4_set_acc", set_acc, 1);
    go(4);
    chk("jif_s5_set_iar", set_iar, 1);
    go(5);
    chk("jif0_ena_ram", ena_ram, 0);
    chk("jif0_set_iar", set_iar, 0);
    run(8'h80, 4'b1000);
    chk("set_c", flags, 4'b1000);
    run(8'h58, 4'b0000);
    chk("jif1_ena_ram", ena_ram, 1);
    chk("jif1_set_iar", set_iar, 1);
    run(8'h80, 4'b1111);
    chk("all_flags", flags, 4'b1111);
    ir = 8'h60; alu_flags = 4'b1111;
    go(0); go(1); go(2); go(3);
    chk("clf_s4_bus1", bus1, 1);
    go(4);
    chk("clf_flags", flags, 4'b0000);
    go(5);
    ir = 8'h07; alu_flags = 4'b0000;
    go(0); go(1); go(2);
    clke = 1'b0;
    go(3);
    chk("ld_s4_ena_gated", ena_reg, 0);
    chk("ld_s4_set_mar", set_mar, 1);
    clke = 1'b1; clks = 1'b0;
    go(4);
    chk("ld_s5_ena_ram", ena_ram, 1);
    chk("ld_s5_set_gated", set_reg, 0);
    clks = 1'b1;
    go(4);
    chk("ld_s5_set_reg", set_reg, 4'b1000);
    go(5);
    chk("wrap_seq_err", seq_err, 0);
    go(0); go(1); go(3);
    chk("skip_pre_err", seq_err, 0);
    go(4);
    chk("skip_err", seq_err, 1);
    go(5); go(0);
    chk("err_sticky", seq_err, 1);
    chk("err_decode_bus1", bus1, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("err_cleared", seq_err, 0);
    go(1);
    chk("wait_no_err", seq_err, 0);
    go(0); go(1);
    @(negedge clk); step = 6'b000000; #1;
    chk("zero_ena_ram", ena_ram, 0);
    chk("zero_set_ir", set_ir, 0);
    go(2);
    chk("zero_err", seq_err, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
